rtc_burst_ctrl: RTL and testbench
=================================

Name: rtc_burst_ctrl

Overview:
- Register-sequencer between user logic and the existing IIC master (request/done interface, 7-bit device address, 8-bit register address, byte-wise wr/rd valid strobes).
- Periodically burst-reads NUM_REGS consecutive RTC registers into a shadow time bus, and burst-writes a full time set on request.
- Generalises the single-byte, key-driven RTC access to N-byte bursts with auto-poll, arbitration, completion checking and timeout.

Parameters:
- NUM_REGS, 7, registers per burst (1..16).
- DEV_ADDR, 7'h68, RTC device address.
- START_ADDR, 8'h00, first register address of every burst.
- POLL_CYCLES, 50_000_000, sysclk cycles between auto reads; 0 disables auto poll.
- TIMEOUT_CYCLES, 1_000_000, max sysclk cycles from iic_req to iic_done.

Ports:
- sysclk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- set_req  in  1  write request; accepted when set_req & set_ready
- set_data  in  NUM_REGS*8  time to write; byte k (bits 8k+7:8k) goes to START_ADDR+k
- set_ready  out  1  high when no write is pending or in progress
- rd_req  in  1  manual read request (1-cycle pulse)
- time_data  out  NUM_REGS*8  last complete read; byte k from START_ADDR+k
- time_valid  out  1  1-cycle pulse when time_data updates
- err  out  1  1-cycle pulse on short burst or timeout
- iic_req  out  1  1-cycle transfer start pulse
- iic_mode  out  1  0 = write, 1 = read; stable from iic_req until iic_done
- iic_addr_divice  out  7  constant DEV_ADDR
- iic_addr_reg  out  8  constant START_ADDR
- iic_wr_length, iic_rd_length  out  5  constant NUM_REGS
- iic_wr_data  out  8  current write byte
- iic_wr_valid  in  1  master consumed iic_wr_data; advance
- iic_rd_data  in  8  read byte
- iic_rd_valid  in  1  iic_rd_data valid
- iic_busy  in  1  master busy
- iic_done  in  1  1-cycle transfer complete

Behaviour:
- Reset values:
  - time_data = 0; time_valid, err, iic_req, iic_mode = 0; iic_wr_data = 0; set_ready = 1.
  - All counters and pending flags clear; FSM in IDLE.
  - Reset mid-transfer abandons the transfer without waiting for iic_done.
- Pending flags:
  - wr_pend is set on set_req & set_ready; set_data is captured into set_buf the same cycle; set_ready = !wr_pend.
  - rd_pend is set by rd_req or poll expiry; repeated triggers while it is pending merge into one.
- Poll timer:
  - Free-runs 0..POLL_CYCLES-1 in every state; sets rd_pend at terminal count, then wraps to 0.
  - With POLL_CYCLES = 0 the timer is not generated.
- FSM IDLE:
  - If iic_busy is high, stay in IDLE.
  - Else if wr_pend, go to WR_START. Else if rd_pend, go to RD_START. Write wins on simultaneity.
- WR_START: drive iic_req = 1 and iic_mode = 0 for one cycle; clear idx and watchdog; go to WR_WAIT.
- WR_WAIT:
  - iic_wr_data = set_buf byte idx.
  - Each iic_wr_valid increments idx, saturating at NUM_REGS; iic_wr_data then holds 0.
  - On iic_done: clear wr_pend (set_ready rises the next cycle). If idx != NUM_REGS, pulse err. Return to IDLE.
- RD_START: iic_req = 1 and iic_mode = 1 for one cycle; clear idx and watchdog; clear rd_pend; go to RD_WAIT.
- RD_WAIT:
  - Each iic_rd_valid with idx < NUM_REGS stores iic_rd_data into rd_buf byte idx and increments idx. Extra bytes are ignored.
  - On iic_done with idx == NUM_REGS: time_data <= rd_buf and time_valid pulses in the same cycle.
  - On iic_done otherwise: err pulses and time_data is kept.
  - Return to IDLE.
- iic_rd_valid and iic_done in the same cycle: the byte is stored first and included in the count check.
- Watchdog:
  - Counts in WR_WAIT and RD_WAIT.
  - Reaching TIMEOUT_CYCLES pulses err and returns to IDLE. A timed-out write keeps wr_pend and is retried; a timed-out read drops.
- iic_wr_valid and iic_rd_valid outside the matching WAIT state are ignored.
- Throughput: at most one transfer in flight. From iic_done, the next iic_req is issued no earlier than 2 cycles later.

Test Plan:
- Read burst: after reset, pulse rd_req; master model returns 8'h00,01,...,06 then iic_done → exactly one iic_req with iic_mode = 1; time_data = 56'h06050403020100; one time_valid pulse; err stays 0.
- Write burst: set_req with set_data = 56'h24_12_31_05_23_59_50 → set_ready drops the next cycle; iic_mode = 0; bytes 50, 59, 23, 05, 31, 12, 24 presented in order on successive iic_wr_valid; set_ready returns high after iic_done.
- Arbitration: set_req and poll expiry in the same cycle (POLL_CYCLES = 100) → write transfer first, read transfer immediately after; set_req while wr_pend = 1 is ignored (set_buf unchanged).
- Short read: master gives 4 rd_valid then iic_done → err pulses once; time_data keeps its previous value; no time_valid.
- Timeout: master never asserts iic_done (TIMEOUT_CYCLES = 1000) → err after 1000 WAIT cycles; a pending write is retried with identical bytes.
- Reset mid-read after 3 bytes → all outputs return to reset values the next cycle; a subsequent rd_req completes normally.

Source files
------------

// File: rtl/rtc_burst_ctrl.sv
// Register sequencer for an RTC behind a byte-wise IIC master.
// Burst-reads NUM_REGS registers into a shadow time bus and burst-writes a full time set.
module rtc_burst_ctrl #(
  parameter int unsigned NUM_REGS       = 7,
  parameter logic [6:0]  DEV_ADDR       = 7'h68,
  parameter logic [7:0]  START_ADDR     = 8'h00,
  parameter int unsigned POLL_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  set_req,
  input  logic [NUM_REGS*8-1:0] set_data,
  output logic                  set_ready,
  input  logic                  rd_req,
  output logic [NUM_REGS*8-1:0] time_data,
  output logic                  time_valid,
  output logic                  err,
  output logic                  iic_req,
  output logic                  iic_mode,
  output logic [6:0]            iic_addr_divice,
  output logic [7:0]            iic_addr_reg,
  output logic [4:0]            iic_wr_length,
  output logic [4:0]            iic_rd_length,
  output logic [7:0]            iic_wr_data,
  input  logic                  iic_wr_valid,
  input  logic [7:0]            iic_rd_data,
  input  logic                  iic_rd_valid,
  input  logic                  iic_busy,
  input  logic                  iic_done
);

  localparam int unsigned DataW = NUM_REGS * 8;
  localparam int unsigned IdxW  = $clog2(NUM_REGS + 1);
  localparam int unsigned WdW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IdxW-1:0] IdxFull = IdxW'(NUM_REGS);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StWrStart, StWrWait, StRdStart, StRdWait} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DataW-1:0]  set_buf_q, set_buf_d;
  logic [DataW-1:0]  rd_buf_q, rd_buf_d;
  logic [DataW-1:0]  time_data_q, time_data_d;
  logic              time_valid_q, time_valid_d;
  logic              err_q, err_d;
  logic              iic_req_q, iic_req_d;
  logic              iic_mode_q, iic_mode_d;
  logic              poll_hit;
  logic              rd_trig;
  logic [7:0]        wr_byte;

  if (POLL_CYCLES > 0) begin : g_poll
    localparam int unsigned PollW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    logic [PollW-1:0] poll_cnt_q, poll_cnt_d;

    assign poll_hit = (poll_cnt_q == PollW'(POLL_CYCLES - 1));

    always_comb begin
      poll_cnt_d = poll_hit ? '0 : poll_cnt_q + PollW'(1);
    end

    always_ff @(posedge sysclk) begin
      if (rst) poll_cnt_q <= '0;
      else     poll_cnt_q <= poll_cnt_d;
    end
  end else begin : g_no_poll
    assign poll_hit = 1'b0;
  end

  assign rd_trig = rd_req | poll_hit;

  // Byte idx of the captured set; reads as zero once all bytes are consumed.
  always_comb begin
    wr_byte = 8'h00;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (idx_q == IdxW'(k)) wr_byte = set_buf_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wd_d         = wd_q;
    wr_pend_d    = wr_pend_q;
    rd_pend_d    = rd_pend_q | rd_trig;
    set_buf_d    = set_buf_q;
    rd_buf_d     = rd_buf_q;
    time_data_d  = time_data_q;
    time_valid_d = 1'b0;
    err_d        = 1'b0;
    iic_req_d    = 1'b0;
    iic_mode_d   = iic_mode_q;

    if (set_req && !wr_pend_q) begin
      wr_pend_d = 1'b1;
      set_buf_d = set_data;
    end

    unique case (state_q)
      StIdle: begin
        if (!iic_busy) begin
          if (wr_pend_q) begin
            state_d    = StWrStart;
            iic_req_d  = 1'b1;
            iic_mode_d = 1'b0;
          end else if (rd_pend_q) begin
            state_d    = StRdStart;
            iic_req_d  = 1'b1;
            iic_mode_d = 1'b1;
          end
        end
      end
      StWrStart: begin
        idx_d   = '0;
        wd_d    = '0;
        state_d = StWrWait;
      end
      StRdStart: begin
        idx_d     = '0;
        wd_d      = '0;
        rd_pend_d = rd_trig;
        state_d   = StRdWait;
      end
      StWrWait: begin
        if (iic_wr_valid && idx_q != IdxFull) idx_d = idx_q + IdxW'(1);
        if (iic_done) begin
          wr_pend_d = 1'b0;
          err_d     = (idx_d != IdxFull);
          state_d   = StIdle;
        end else if (wd_q == WdLast) begin
          // Write stays pending and is retried from the first byte.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StRdWait: begin
        if (iic_rd_valid && idx_q != IdxFull) begin
          for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (idx_q == IdxW'(k)) rd_buf_d[8*k +: 8] = iic_rd_data;
          end
          idx_d = idx_q + IdxW'(1);
        end
        if (iic_done) begin
          if (idx_d == IdxFull) begin
            time_data_d  = rd_buf_d;
            time_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end else if (wd_q == WdLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      wd_q         <= '0;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      set_buf_q    <= '0;
      rd_buf_q     <= '0;
      time_data_q  <= '0;
      time_valid_q <= 1'b0;
      err_q        <= 1'b0;
      iic_req_q    <= 1'b0;
      iic_mode_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wd_q         <= wd_d;
      wr_pend_q    <= wr_pend_d;
      rd_pend_q    <= rd_pend_d;
      set_buf_q    <= set_buf_d;
      rd_buf_q     <= rd_buf_d;
      time_data_q  <= time_data_d;
      time_valid_q <= time_valid_d;
      err_q        <= err_d;
      iic_req_q    <= iic_req_d;
      iic_mode_q   <= iic_mode_d;
    end
  end

  assign set_ready       = ~wr_pend_q;
  assign time_data       = time_data_q;
  assign time_valid      = time_valid_q;
  assign err             = err_q;
  assign iic_req         = iic_req_q;
  assign iic_mode        = iic_mode_q;
  assign iic_addr_divice = DEV_ADDR;
  assign iic_addr_reg    = START_ADDR;
  assign iic_wr_length   = 5'(NUM_REGS);
  assign iic_rd_length   = 5'(NUM_REGS);
  assign iic_wr_data     = (state_q == StWrWait) ? wr_byte : 8'h00;

endmodule

// File: tb/tb_rtc_burst_ctrl.sv
// Directed bench for rtc_burst_ctrl: one instance without auto poll, one polling every 100 cycles
// for the write/poll arbitration case. Both share the IIC master model inputs.
module tb_rtc_burst_ctrl;

  logic        sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        rst, p_rst, set_req, p_set_req, rd_req, p_rd_req;
  logic [55:0] set_data, p_set_data;
  logic        iic_wr_valid, iic_rd_valid, iic_busy, iic_done;
  logic [7:0]  iic_rd_data;

  logic        set_ready, time_valid, err, iic_req, iic_mode;
  logic [55:0] time_data;
  logic [6:0]  iic_addr_divice;
  logic [7:0]  iic_addr_reg, iic_wr_data;
  logic [4:0]  iic_wr_length, iic_rd_length;

  logic        p_set_ready, p_time_valid, p_err, p_iic_req, p_iic_mode;
  logic [55:0] p_time_data;
  logic [6:0]  p_iic_addr_divice;
  logic [7:0]  p_iic_addr_reg, p_iic_wr_data;
  logic [4:0]  p_iic_wr_length, p_iic_rd_length;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int tv_cnt = 0;
  int err_cnt = 0;

  rtc_burst_ctrl #(
    .NUM_REGS(7), .DEV_ADDR(7'h68), .START_ADDR(8'h00), .POLL_CYCLES(0), .TIMEOUT_CYCLES(1000)
  ) u_dut (
    .sysclk(sysclk), .rst(rst), .set_req(set_req), .set_data(set_data), .set_ready(set_ready),
    .rd_req(rd_req), .time_data(time_data), .time_valid(time_valid), .err(err),
    .iic_req(iic_req), .iic_mode(iic_mode), .iic_addr_divice(iic_addr_divice),
    .iic_addr_reg(iic_addr_reg), .iic_wr_length(iic_wr_length), .iic_rd_length(iic_rd_length),
    .iic_wr_data(iic_wr_data), .iic_wr_valid(iic_wr_valid), .iic_rd_data(iic_rd_data),
    .iic_rd_valid(iic_rd_valid), .iic_busy(iic_busy), .iic_done(iic_done)
  );

  rtc_burst_ctrl #(
    .NUM_REGS(7), .DEV_ADDR(7'h68), .START_ADDR(8'h00), .POLL_CYCLES(100), .TIMEOUT_CYCLES(1000)
  ) u_poll (
    .sysclk(sysclk), .rst(p_rst), .set_req(p_set_req), .set_data(p_set_data),
    .set_ready(p_set_ready), .rd_req(p_rd_req), .time_data(p_time_data),
    .time_valid(p_time_valid), .err(p_err), .iic_req(p_iic_req), .iic_mode(p_iic_mode),
    .iic_addr_divice(p_iic_addr_divice), .iic_addr_reg(p_iic_addr_reg),
    .iic_wr_length(p_iic_wr_length), .iic_rd_length(p_iic_rd_length),
    .iic_wr_data(p_iic_wr_data), .iic_wr_valid(iic_wr_valid), .iic_rd_data(iic_rd_data),
    .iic_rd_valid(iic_rd_valid), .iic_busy(iic_busy), .iic_done(iic_done)
  );

  always @(negedge sysclk) begin
    if (iic_req === 1'b1)    req_cnt++;
    if (time_valid === 1'b1) tv_cnt++;
    if (err === 1'b1)        err_cnt++;
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_req(input bit sel, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      tick();
      if ((sel ? p_iic_req : iic_req) === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: iic_req got 0 within 50 cycles, want 1", name);
    end
  endtask

  // Called in the START cycle; returns with the transfer still open.
  task automatic serve_write(input bit sel, input int n, output logic [55:0] got);
    got = '0;
    tick();
    for (int k = 0; k < n; k++) begin
      got[8*k +: 8] = sel ? p_iic_wr_data : iic_wr_data;
      iic_wr_valid = 1'b1;
      tick();
      iic_wr_valid = 1'b0;
      tick();
    end
  endtask

  task automatic serve_read(input int n, input logic [7:0] base);
    tick();
    for (int k = 0; k < n; k++) begin
      iic_rd_data  = base + 8'(k);
      iic_rd_valid = 1'b1;
      tick();
      iic_rd_valid = 1'b0;
      tick();
    end
  endtask

  task automatic finish_xfer();
    iic_done = 1'b1;
    tick();
    iic_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks += 11;
    if (time_data !== 56'h0) begin errors++; $display("FAIL rst_time_data: got %h want 0", time_data); end
    if (time_valid !== 1'b0) begin errors++; $display("FAIL rst_time_valid: got %b want 0", time_valid); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    if (iic_req !== 1'b0) begin errors++; $display("FAIL rst_iic_req: got %b want 0", iic_req); end
    if (iic_mode !== 1'b0) begin errors++; $display("FAIL rst_iic_mode: got %b want 0", iic_mode); end
    if (iic_wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data: got %h want 00", iic_wr_data); end
    if (set_ready !== 1'b1) begin errors++; $display("FAIL rst_set_ready: got %b want 1", set_ready); end
    if (iic_addr_divice !== 7'h68) begin errors++; $display("FAIL dev_addr: got %h want 68", iic_addr_divice); end
    if (iic_addr_reg !== 8'h00) begin errors++; $display("FAIL reg_addr: got %h want 00", iic_addr_reg); end
    if (iic_wr_length !== 5'd7) begin errors++; $display("FAIL wr_length: got %0d want 7", iic_wr_length); end
    if (iic_rd_length !== 5'd7) begin errors++; $display("FAIL rd_length: got %0d want 7", iic_rd_length); end
  endtask

  task automatic test_read_burst();
    int r0 = req_cnt, t0 = tv_cnt, e0 = err_cnt;
    bit seen = 1'b0;
    iic_busy = 1'b1;
    rd_req   = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= iic_req;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL busy_hold: iic_req got 1 want 0"); end
    iic_busy = 1'b0;
    wait_req(1'b0, "read_req");
    checks++;
    if (iic_mode !== 1'b1) begin errors++; $display("FAIL read_mode: got %b want 1", iic_mode); end
    serve_read(7, 8'h00);
    finish_xfer();
    checks += 3;
    if (time_data !== 56'h06050403020100) begin
      errors++; $display("FAIL read_data: got %h want 06050403020100", time_data);
    end
    if (time_valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %b want 1", time_valid); end
    if (err !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", err); end
    repeat (3) tick();
    checks += 3;
    if (req_cnt - r0 !== 1) begin errors++; $display("FAIL read_req_count: got %0d want 1", req_cnt - r0); end
    if (tv_cnt - t0 !== 1) begin errors++; $display("FAIL read_tv_count: got %0d want 1", tv_cnt - t0); end
    if (err_cnt - e0 !== 0) begin errors++; $display("FAIL read_err_count: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_write_burst();
    logic [55:0] got;
    int e0 = err_cnt;
    set_data = 56'h24_12_31_05_23_59_50;
    set_req  = 1'b1;
    tick();
    set_req = 1'b0;
    checks++;
    if (set_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_drop: got %b want 0", set_ready); end
    wait_req(1'b0, "write_req");
    checks++;
    if (iic_mode !== 1'b0) begin errors++; $display("FAIL write_mode: got %b want 0", iic_mode); end
    // Competing request for the whole transfer must not disturb the captured bytes.
    set_data = 56'hff_ee_dd_cc_bb_aa_99;
    set_req  = 1'b1;
    serve_write(1'b0, 7, got);
    set_req = 1'b0;
    checks += 3;
    if (got !== 56'h24_12_31_05_23_59_50) begin
      errors++; $display("FAIL write_bytes: got %h want 24123105235950", got);
    end
    if (iic_wr_data !== 8'h00) begin errors++; $display("FAIL write_sat: got %h want 00", iic_wr_data); end
    if (set_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_busy: got %b want 0", set_ready); end
    finish_xfer();
    tick();
    checks += 2;
    if (set_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_back: got %b want 1", set_ready); end
    if (err_cnt - e0 !== 0) begin errors++; $display("FAIL write_err_count: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_short_read();
    int t0 = tv_cnt;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    wait_req(1'b0, "short_req");
    serve_read(4, 8'ha0);
    finish_xfer();
    checks += 3;
    if (err !== 1'b1) begin errors++; $display("FAIL short_err: got %b want 1", err); end
    if (time_data !== 56'h06050403020100) begin
      errors++; $display("FAIL short_keep: got %h want 06050403020100", time_data);
    end
    if (time_valid !== 1'b0) begin errors++; $display("FAIL short_valid: got %b want 0", time_valid); end
    tick();
    checks += 2;
    if (err !== 1'b0) begin errors++; $display("FAIL short_err_pulse: got %b want 0", err); end
    if (tv_cnt - t0 !== 0) begin errors++; $display("FAIL short_tv_count: got %0d want 0", tv_cnt - t0); end
  endtask

  task automatic test_timeout();
    logic [55:0] got;
    int n;
    set_data = 56'h01_02_03_04_05_06_07;
    set_req  = 1'b1;
    tick();
    set_req = 1'b0;
    wait_req(1'b0, "to_req");
    serve_write(1'b0, 2, got);
    n = 5;
    while (err !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 1001) begin errors++; $display("FAIL timeout_cycles: got %0d want 1001", n); end
    tick();
    checks += 3;
    if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_pulse: got %b want 0", err); end
    if (iic_req !== 1'b1) begin errors++; $display("FAIL retry_req: got %b want 1", iic_req); end
    if (iic_mode !== 1'b0) begin errors++; $display("FAIL retry_mode: got %b want 0", iic_mode); end
    serve_write(1'b0, 7, got);
    finish_xfer();
    checks += 3;
    if (got !== 56'h01_02_03_04_05_06_07) begin
      errors++; $display("FAIL retry_bytes: got %h want 01020304050607", got);
    end
    if (err !== 1'b0) begin errors++; $display("FAIL retry_err: got %b want 0", err); end
    tick();
    if (set_ready !== 1'b1) begin errors++; $display("FAIL retry_ready: got %b want 1", set_ready); end
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    wait_req(1'b0, "mid_req");
    serve_read(3, 8'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 6;
    if (time_data !== 56'h0) begin errors++; $display("FAIL mid_time_data: got %h want 0", time_data); end
    if (time_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", time_valid); end
    if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", err); end
    if (iic_req !== 1'b0) begin errors++; $display("FAIL mid_req_low: got %b want 0", iic_req); end
    if (iic_mode !== 1'b0) begin errors++; $display("FAIL mid_mode: got %b want 0", iic_mode); end
    if (set_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", set_ready); end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    wait_req(1'b0, "after_rst_req");
    serve_read(7, 8'h10);
    finish_xfer();
    checks += 2;
    if (time_data !== 56'h16151413121110) begin
      errors++; $display("FAIL after_rst_data: got %h want 16151413121110", time_data);
    end
    if (time_valid !== 1'b1) begin errors++; $display("FAIL after_rst_valid: got %b want 1", time_valid); end
  endtask

  task automatic test_arbitration();
    logic [55:0] got;
    p_rst = 1'b1;
    tick();
    tick();
    p_rst = 1'b0;
    // Poll counter is 0 now and reaches its terminal count 99 cycles later.
    repeat (99) tick();
    p_set_data = 56'h11_22_33_44_55_66_77;
    p_set_req  = 1'b1;
    tick();
    p_set_req = 1'b0;
    wait_req(1'b1, "arb_wr_req");
    checks++;
    if (p_iic_mode !== 1'b0) begin errors++; $display("FAIL arb_first_mode: got %b want 0", p_iic_mode); end
    serve_write(1'b1, 7, got);
    finish_xfer();
    checks += 2;
    if (got !== 56'h11_22_33_44_55_66_77) begin
      errors++; $display("FAIL arb_wr_bytes: got %h want 11223344556677", got);
    end
    if (p_iic_req !== 1'b0) begin errors++; $display("FAIL arb_gap: got %b want 0", p_iic_req); end
    tick();
    checks += 2;
    if (p_iic_req !== 1'b1) begin errors++; $display("FAIL arb_rd_req: got %b want 1", p_iic_req); end
    if (p_iic_mode !== 1'b1) begin errors++; $display("FAIL arb_rd_mode: got %b want 1", p_iic_mode); end
    serve_read(7, 8'h30);
    finish_xfer();
    checks += 2;
    if (p_time_valid !== 1'b1) begin errors++; $display("FAIL arb_rd_valid: got %b want 1", p_time_valid); end
    if (p_time_data !== 56'h36353433323130) begin
      errors++; $display("FAIL arb_rd_data: got %h want 36353433323130", p_time_data);
    end
  endtask

  initial begin
    rst          = 1'b1;
    p_rst        = 1'b1;
    set_req      = 1'b0;
    p_set_req    = 1'b0;
    rd_req       = 1'b0;
    p_rd_req     = 1'b0;
    set_data     = '0;
    p_set_data   = '0;
    iic_wr_valid = 1'b0;
    iic_rd_valid = 1'b0;
    iic_rd_data  = 8'h00;
    iic_busy     = 1'b0;
    iic_done     = 1'b0;
    test_reset();
    test_read_burst();
    test_write_burst();
    test_short_read();
    test_timeout();
    test_reset_mid_read();
    test_arbitration();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
